// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, M-stage and memory-side signals around the shared
// instruction/data memory port. The arbiter uses the slave view; the
// pipeline/memory side (or a bench) uses the master view.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_addr;
    logic            if_redirect;
    logic [XLEN-1:0] if_instr;
    logic            if_stall;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_be;
    logic            d_next;
    logic [XLEN-1:0] d_rdata;
    logic            d_done;
    logic            d_stall;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_addr, if_redirect, d_req, d_we, d_addr, d_wdata, d_be, d_next,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_instr, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_addr, if_redirect, d_req, d_we, d_addr, d_wdata, d_be, d_next,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_instr, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// M-stage load/store unit. One transaction in flight, data wins ties, and a
// one-entry tagged instruction buffer absorbs repeated fetches of the same PC.
//
// state  | meaning
// IDLE   | nothing in flight; present data or fetch request to memory
// I_WAIT | fetch granted, waiting for its response (kill drops it)
// D_WAIT | data access granted, waiting for its response
module mem_port_arbiter #(
    parameter int              XLEN = 32,
    parameter logic [XLEN-1:0] NOP  = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus_if
);
    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    state_t          state_q, state_d;
    logic            ibuf_valid_q, ibuf_valid_d;
    logic [XLEN-1:0] ibuf_tag_q, ibuf_tag_d;
    logic [XLEN-1:0] ibuf_data_q, ibuf_data_d;
    logic [XLEN-1:0] req_tag_q, req_tag_d;
    logic            kill_q, kill_d;
    logic            d_served_q, d_served_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;

    logic            buf_hit, bypass_hit, fetch_hit, d_pend, d_done;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [3:0]      mem_be;

    // Fetch hit detection: buffered instruction or same-cycle bypass of a live response.
    always_comb begin
        buf_hit    = ibuf_valid_q && (ibuf_tag_q == bus_if.if_addr);
        bypass_hit = (state_q == I_WAIT) && bus_if.mem_rvalid && !kill_q
                     && !bus_if.if_redirect && (req_tag_q == bus_if.if_addr);
        fetch_hit  = buf_hit || bypass_hit;
        d_pend     = bus_if.d_req && !d_served_q;
    end

    // Next-state and memory request logic; data requests take priority in IDLE.
    always_comb begin
        state_d      = state_q;
        ibuf_valid_d = ibuf_valid_q;
        ibuf_tag_d   = ibuf_tag_q;
        ibuf_data_d  = ibuf_data_q;
        req_tag_d    = req_tag_q;
        kill_d       = kill_q;
        d_served_d   = d_served_q;
        d_rdata_d    = d_rdata_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = 4'h0;
        d_done       = 1'b0;

        case (state_q)
            IDLE: begin
                // Reset gating keeps the port quiet while the pipeline is held.
                if (rst_n) begin
                    if (d_pend) begin
                        mem_req   = 1'b1;
                        mem_we    = bus_if.d_we;
                        mem_addr  = bus_if.d_addr;
                        mem_wdata = bus_if.d_wdata;
                        mem_be    = bus_if.d_be;
                        if (bus_if.mem_gnt) state_d = D_WAIT;
                    end else if (!fetch_hit && !bus_if.if_redirect) begin
                        mem_req  = 1'b1;
                        mem_be   = 4'hF;
                        mem_addr = bus_if.if_addr;
                        if (bus_if.mem_gnt) begin
                            state_d   = I_WAIT;
                            req_tag_d = bus_if.if_addr;
                            kill_d    = 1'b0;
                        end
                    end
                end
            end
            I_WAIT: begin
                if (bus_if.if_redirect) kill_d = 1'b1;
                if (bus_if.mem_rvalid) begin
                    if (!kill_q && !bus_if.if_redirect) begin
                        ibuf_valid_d = 1'b1;
                        ibuf_tag_d   = req_tag_q;
                        ibuf_data_d  = bus_if.mem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            D_WAIT: begin
                if (bus_if.mem_rvalid) begin
                    d_done = 1'b1;
                    if (!bus_if.d_we) d_rdata_d = bus_if.mem_rdata;
                    d_served_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new M-stage instruction re-arms the data port, even in its completion cycle.
        if (bus_if.d_next)      d_served_d   = 1'b0;
        if (bus_if.if_redirect) ibuf_valid_d = 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ibuf_valid_q <= 1'b0;
            ibuf_tag_q   <= '0;
            ibuf_data_q  <= '0;
            req_tag_q    <= '0;
            kill_q       <= 1'b0;
            d_served_q   <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_tag_q   <= ibuf_tag_d;
            ibuf_data_q  <= ibuf_data_d;
            req_tag_q    <= req_tag_d;
            kill_q       <= kill_d;
            d_served_q   <= d_served_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus_if.if_instr  = bypass_hit ? bus_if.mem_rdata : (buf_hit ? ibuf_data_q : NOP);
    assign bus_if.if_stall  = !fetch_hit;
    assign bus_if.d_rdata   = d_rdata_q;
    assign bus_if.d_done    = d_done;
    assign bus_if.d_stall   = d_pend && !d_done;
    assign bus_if.mem_req   = mem_req;
    assign bus_if.mem_we    = mem_we;
    assign bus_if.mem_addr  = mem_addr;
    assign bus_if.mem_wdata = mem_wdata;
    assign bus_if.mem_be    = mem_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table driving the
// pipeline and memory sides, plus hand-written store/backpressure and
// mid-transaction reset sequences.
module tb_mem_port_arbiter;
    localparam logic [31:0] NOPV = 32'h00000013;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   nreq;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        redir;
        logic        dreq;
        logic [31:0] daddr;
        logic        dnext;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [31:0] e_instr;
        logic        e_istall;
        logic        e_done;
        logic        e_dstall;
        logic        e_req;
        logic [31:0] e_maddr;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] addr, logic redir, logic dreq, logic [31:0] daddr,
                                logic dnext, logic gnt, logic rv, logic [31:0] rdata,
                                logic [31:0] e_instr, logic e_istall, logic e_done,
                                logic e_dstall, logic e_req, logic [31:0] e_maddr,
                                logic [31:0] e_drdata);
        vec_t v;
        v.addr = addr; v.redir = redir; v.dreq = dreq; v.daddr = daddr; v.dnext = dnext;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.e_instr = e_instr; v.e_istall = e_istall;
        v.e_done = e_done; v.e_dstall = e_dstall; v.e_req = e_req; v.e_maddr = e_maddr;
        v.e_drdata = e_drdata;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_addr = '0; bus.if_redirect = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = 4'h0; bus.d_next = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    initial begin
        //            addr     rd dq daddr     dn g  rv rdata          instr          is dn ds rq maddr     drdata
        tbl.push_back(mk(32'h00, 0, 0, 32'h000, 0, 1, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h00,  32'h0));
        tbl.push_back(mk(32'h00, 0, 0, 32'h000, 0, 0, 1, 32'h00500093, 32'h00500093,  0, 0, 0, 0, 32'h00,  32'h0));
        tbl.push_back(mk(32'h00, 0, 0, 32'h000, 0, 0, 0, 32'h0,        32'h00500093,  0, 0, 0, 0, 32'h00,  32'h0));
        tbl.push_back(mk(32'h10, 0, 0, 32'h000, 0, 1, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h10,  32'h0));
        tbl.push_back(mk(32'h10, 1, 0, 32'h000, 0, 0, 0, 32'h0,        NOPV,          1, 0, 0, 0, 32'h00,  32'h0));
        tbl.push_back(mk(32'h40, 0, 0, 32'h000, 0, 0, 1, 32'hAAAAAAAA, NOPV,          1, 0, 0, 0, 32'h00,  32'h0));
        tbl.push_back(mk(32'h40, 0, 0, 32'h000, 0, 0, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h40,  32'h0));
        tbl.push_back(mk(32'h40, 0, 0, 32'h000, 0, 1, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h40,  32'h0));
        tbl.push_back(mk(32'h40, 0, 0, 32'h000, 0, 0, 1, 32'h11111111, 32'h11111111,  0, 0, 0, 0, 32'h00,  32'h0));
        tbl.push_back(mk(32'h80, 0, 1, 32'h100, 0, 1, 0, 32'h0,        NOPV,          1, 0, 1, 1, 32'h100, 32'h0));
        tbl.push_back(mk(32'h80, 0, 1, 32'h100, 1, 0, 1, 32'hCAFEF00D, NOPV,          1, 1, 0, 0, 32'h00,  32'h0));
        tbl.push_back(mk(32'h80, 0, 0, 32'h000, 0, 1, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h80,  32'hCAFEF00D));
        tbl.push_back(mk(32'h80, 0, 0, 32'h000, 0, 0, 1, 32'h22222222, 32'h22222222,  0, 0, 0, 0, 32'h00,  32'hCAFEF00D));
        tbl.push_back(mk(32'h90, 0, 0, 32'h000, 0, 1, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h90,  32'hCAFEF00D));
        tbl.push_back(mk(32'h90, 0, 1, 32'h104, 0, 0, 0, 32'h0,        NOPV,          1, 0, 1, 0, 32'h00,  32'hCAFEF00D));
        tbl.push_back(mk(32'h90, 0, 1, 32'h104, 0, 1, 1, 32'h33333333, 32'h33333333,  0, 0, 1, 0, 32'h00,  32'hCAFEF00D));
        tbl.push_back(mk(32'h90, 0, 1, 32'h104, 0, 1, 0, 32'h0,        32'h33333333,  0, 0, 1, 1, 32'h104, 32'hCAFEF00D));
        tbl.push_back(mk(32'h90, 0, 1, 32'h104, 1, 0, 1, 32'h44444444, 32'h33333333,  0, 1, 0, 0, 32'h00,  32'hCAFEF00D));
        tbl.push_back(mk(32'h90, 0, 0, 32'h000, 0, 0, 0, 32'h0,        32'h33333333,  0, 0, 0, 0, 32'h00,  32'h44444444));
        tbl.push_back(mk(32'hA0, 0, 0, 32'h000, 0, 1, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'hA0,  32'h44444444));
        tbl.push_back(mk(32'hA0, 1, 0, 32'h000, 0, 0, 1, 32'h55555555, NOPV,          1, 0, 0, 0, 32'h00,  32'h44444444));
        tbl.push_back(mk(32'h90, 0, 0, 32'h000, 0, 0, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h90,  32'h44444444));
        tbl.push_back(mk(32'h90, 0, 0, 32'h000, 0, 1, 0, 32'h0,        NOPV,          1, 0, 0, 1, 32'h90,  32'h44444444));
        tbl.push_back(mk(32'h90, 0, 0, 32'h000, 0, 0, 1, 32'h66666666, 32'h66666666,  0, 0, 0, 0, 32'h00,  32'h44444444));

        // Reset state.
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.mem_req",  {31'b0, bus.mem_req},  32'd0);
        chk("rst.d_done",   {31'b0, bus.d_done},   32'd0);
        chk("rst.if_stall", {31'b0, bus.if_stall}, 32'd1);
        chk("rst.if_instr", bus.if_instr,          NOPV);
        chk("rst.d_rdata",  bus.d_rdata,           32'd0);
        tick();
        rst_n = 1'b1;

        // Vector table, one clock per record.
        for (int i = 0; i < tbl.size(); i++) begin
            bus.if_addr = tbl[i].addr;  bus.if_redirect = tbl[i].redir;
            bus.d_req = tbl[i].dreq;    bus.d_we = 1'b0;
            bus.d_addr = tbl[i].daddr;  bus.d_wdata = '0; bus.d_be = 4'hF;
            bus.d_next = tbl[i].dnext;  bus.mem_gnt = tbl[i].gnt;
            bus.mem_rvalid = tbl[i].rv; bus.mem_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d.if_instr", i), bus.if_instr, tbl[i].e_instr);
            chk($sformatf("v%0d.if_stall", i), {31'b0, bus.if_stall}, {31'b0, tbl[i].e_istall});
            chk($sformatf("v%0d.d_done", i),   {31'b0, bus.d_done},   {31'b0, tbl[i].e_done});
            chk($sformatf("v%0d.d_stall", i),  {31'b0, bus.d_stall},  {31'b0, tbl[i].e_dstall});
            chk($sformatf("v%0d.mem_req", i),  {31'b0, bus.mem_req},  {31'b0, tbl[i].e_req});
            chk($sformatf("v%0d.mem_addr", i), bus.mem_addr,          tbl[i].e_maddr);
            chk($sformatf("v%0d.mem_we", i),   {31'b0, bus.mem_we},   32'd0);
            chk($sformatf("v%0d.d_rdata", i),  bus.d_rdata,           tbl[i].e_drdata);
            tick();
        end

        // Store under 4 cycles of backpressure, then held request must not re-issue.
        idle_inputs();
        bus.if_addr = 32'h90; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200;
        bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            bus.mem_gnt = (i == 4);
            @(negedge clk);
            chk($sformatf("st%0d.mem_req", i),   {31'b0, bus.mem_req},  32'd1);
            chk($sformatf("st%0d.mem_we", i),    {31'b0, bus.mem_we},   32'd1);
            chk($sformatf("st%0d.mem_addr", i),  bus.mem_addr,          32'h200);
            chk($sformatf("st%0d.mem_wdata", i), bus.mem_wdata,         32'hDEADBEEF);
            chk($sformatf("st%0d.mem_be", i),    {28'b0, bus.mem_be},   32'h3);
            chk($sformatf("st%0d.d_stall", i),   {31'b0, bus.d_stall},  32'd1);
            chk($sformatf("st%0d.if_stall", i),  {31'b0, bus.if_stall}, 32'd0);
            tick();
        end
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("st.d_done",  {31'b0, bus.d_done},  32'd1);
        chk("st.d_stall", {31'b0, bus.d_stall}, 32'd0);
        tick();
        bus.mem_rvalid = 0; bus.mem_gnt = 1;
        nreq = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mem_req) nreq++;
            chk($sformatf("hold%0d.d_stall", i), {31'b0, bus.d_stall}, 32'd0);
            chk($sformatf("hold%0d.d_done", i),  {31'b0, bus.d_done},  32'd0);
            tick();
        end
        chk("hold.reissues", nreq, 32'd0);
        chk("st.d_rdata_kept", bus.d_rdata, 32'h44444444);
        bus.mem_gnt = 0; bus.d_next = 1;
        @(negedge clk);
        chk("dnext.mem_req", {31'b0, bus.mem_req}, 32'd0);
        tick();
        bus.d_next = 0;
        @(negedge clk);
        chk("rearm.mem_req", {31'b0, bus.mem_req}, 32'd1);
        chk("rearm.d_stall", {31'b0, bus.d_stall}, 32'd1);
        tick();

        // Reset during D_WAIT; late response must be ignored.
        idle_inputs();
        bus.if_addr = 32'h90; bus.d_req = 1; bus.d_addr = 32'h300; bus.mem_gnt = 1;
        @(negedge clk);
        chk("rd.mem_req",  {31'b0, bus.mem_req}, 32'd1);
        chk("rd.mem_addr", bus.mem_addr,         32'h300);
        tick();
        bus.mem_gnt = 0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mrst.mem_req",  {31'b0, bus.mem_req},  32'd0);
        chk("mrst.d_done",   {31'b0, bus.d_done},   32'd0);
        chk("mrst.if_stall", {31'b0, bus.if_stall}, 32'd1);
        chk("mrst.if_instr", bus.if_instr,          NOPV);
        chk("mrst.d_rdata",  bus.d_rdata,           32'd0);
        tick();
        rst_n = 1'b1;
        bus.d_req = 0; bus.if_addr = 32'h0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("late.d_done",   {31'b0, bus.d_done},   32'd0);
        chk("late.d_rdata",  bus.d_rdata,           32'd0);
        chk("late.if_stall", {31'b0, bus.if_stall}, 32'd1);
        chk("late.mem_req",  {31'b0, bus.mem_req},  32'd1);
        chk("late.mem_addr", bus.mem_addr,          32'h0);
        tick();
        bus.mem_rvalid = 0; bus.mem_gnt = 1;
        @(negedge clk);
        chk("refetch.mem_req", {31'b0, bus.mem_req}, 32'd1);
        tick();
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h99999999;
        @(negedge clk);
        chk("refetch.if_instr", bus.if_instr,          32'h99999999);
        chk("refetch.if_stall", {31'b0, bus.if_stall}, 32'd0);
        chk("refetch.d_done",   {31'b0, bus.d_done},   32'd0);
        tick();
        bus.mem_rvalid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
